// File: rtl/drain_count.sv
// ============================================================================
//  Module      : drain_count
//  Description : Read-side burst drainer; waits for `full`, reads DEPTH
//                entries on downstream `ready`, pulses `done`, then re-arms.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module drain_count #(
   parameter int DEPTH = 6,
   parameter int AW    = 3
) (
   input  logic          clock,
   input  logic          rst_n,
   input  logic          full,
   input  logic          ready,
   output logic          read,
   output logic [AW-1:0] raddr,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_READ     = 2'd1,
      S_DONE     = 2'd2,
      S_WAIT_CLR = 2'd3
   } state_t;

   // Terminal compare is on DEPTH-1 so DEPTH == 2**AW never overflows count.
   localparam logic [AW-1:0] c_last = AW'(DEPTH - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] count_q, count_d;
   logic          busy_q,  busy_d;
   logic          done_q,  done_d;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      read    = 1'b0;
      case (state_q)
         S_IDLE: begin
            count_d = '0;
            if (full) state_d = S_READ;
         end
         S_READ: begin
            read = ready;
            if (ready) begin
               if (count_q == c_last) begin
                  count_d = '0;
                  state_d = S_DONE;
               end else begin
                  count_d = count_q + AW'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_WAIT_CLR;
         end
         S_WAIT_CLR: begin
            // A stale `full` must be seen low before another burst is allowed.
            if (!full) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            count_d = '0;
         end
      endcase
      busy_d = (state_d == S_READ) || (state_d == S_DONE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign raddr = count_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

`default_nettype wire

// File: doc/drain_count.md
Name: drain_count

Overview:
- Read-side companion to the capture counter.
- Waits for the capture side's `full` flag, then drains exactly DEPTH stored entries.
- Issues one read strobe and one read address per accepted downstream `ready` cycle.
- After the last entry, pulses `done` so the capture counter can be cleared, then re-arms only after `full` has dropped.

Parameters:
- DEPTH, 6: number of entries drained per burst. Legal range 1..2**AW; matches the capture counter's full point.
- AW, 3: width of the read address and of the internal entry count.

Ports:
- clock, input, 1: single clock; all state updates on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- full, input, 1: level from the capture side; high means DEPTH entries are held.
- ready, input, 1: downstream consumer can accept one entry this cycle.
- read, output, 1: read strobe, combinational; high for exactly one cycle per entry transferred.
- raddr, output, AW: address of the entry being read; valid whenever `read`=1.
- busy, output, 1: registered; high from burst start until the DONE cycle inclusive.
- done, output, 1: registered; single-cycle pulse marking burst completion. Used as the capture-side clear.

Behaviour:
- Reset, asynchronous on rst_n=0:
  - state=IDLE, count=0.
  - busy=0, done=0, read=0, raddr=0.
  - Applies immediately and regardless of state; a mid-burst reset abandons the burst with no `done` pulse.
- States: IDLE, READ, DONE, WAIT_CLR. Encoding is free; the state register is 2 bits.
- IDLE:
  - busy=0; count held at 0.
  - full=1 sampled at an edge → READ; busy=1 from the next cycle.
- READ:
  - busy=1.
  - read = ready (combinational, gated by state==READ).
  - raddr = count.
  - On an edge with read=1: if count==DEPTH-1, then count←0 and state→DONE; else count←count+1.
  - ready=0 stalls: count and state hold, read=0.
  - `full` is ignored in this state; a drop mid-burst does not abort it.
- DONE:
  - Lasts exactly one cycle; done=1, busy=1, read=0.
  - Next state is WAIT_CLR unconditionally.
- WAIT_CLR:
  - busy=0, done=0, read=0.
  - Stay while full=1; full=0 sampled → IDLE.
  - This prevents re-triggering on a stale `full`.
- Latency:
  - First `read` can occur one cycle after `full` is sampled high.
  - With ready held high, the burst takes DEPTH cycles, and `done` rises the cycle after the last read.
  - Minimum full→done latency is DEPTH+1 cycles.
- Width rules:
  - count is AW bits and never exceeds DEPTH-1.
  - raddr = count, no wrap within a burst; the wrap to 0 occurs only at burst end.
  - DEPTH==2**AW must work with no overflow, because the terminal compare is on DEPTH-1.
- Simultaneous events:
  - full=1 while in DONE or WAIT_CLR: no new burst until full has been observed low.
  - ready toggling every cycle: exactly one read per cycle in which ready=1, and addresses remain sequential.
- Invariants:
  - read implies busy=1.
  - done and read are never high together.
  - done is never high on two consecutive cycles.

Test Plan:
- Reset, then full=1 with ready=1 constantly (DEPTH=6) → read high 6 consecutive cycles, raddr 0,1,2,3,4,5; done=1 the next cycle; busy=0 after that.
- Same burst with ready=1,0,1,0,… → 6 reads spread over 11 cycles, raddr strictly 0..5, and read never high while ready=0.
- full held at 1 for 20 cycles after done → no second burst; full dropped then raised again → a new burst starts at raddr=0.
- rst_n pulled low after raddr=3 is read → all outputs 0 immediately, no done pulse; after release with full=1 → the burst restarts at raddr=0.
- full pulsed high for a single cycle, then low, with ready=1 → the full 6-entry burst completes and done pulses once.
- DEPTH=8, AW=3, ready=1 → raddr 0..7, done after the 8th read, and the count returns to 0 with no overflow glitch.
